// File: rtl/uart_defs.sv
// Shared UART definitions used by the receive controller and the Receiver.
// Holds the byte and error-code widths, the width of one stored receive
// entry, the receive FSM state encodings and a small helper that packs
// an error code and data byte into one FIFO entry.
package uart_defs;

    localparam int DataWidth  = 8;
    localparam int ErrorWidth = 3;
    localparam int EntryWidth = DataWidth + ErrorWidth;

    typedef enum logic [1:0] {
        RX_IDLE        = 2'd0,
        RX_CAPTURE     = 2'd1,
        RX_ACKNOWLEDGE = 2'd2
    } rx_state_e;

    // Entry layout is {error, data} so the error code sits in the top bits.
    function automatic logic [EntryWidth-1:0] pack_entry(
        input logic [ErrorWidth-1:0] err,
        input logic [DataWidth-1:0]  data
    );
        return {err, data};
    endfunction

endpackage

// File: rtl/receive_fifo.sv
// Receive FIFO: show-ahead storage with read/write pointers and occupancy.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   wr_en       - write attempt (accepted when not full, or full with a pop)
//   wr_data     - entry to store
//   rd_req      - pop request (ignored while empty)
//   rd_data     - head entry, combinational
//   rd_valid    - FIFO non-empty
//   level       - occupancy 0..Depth
//   wr_drop     - the write attempt this cycle is refused (full, no pop)
module receive_fifo
    import uart_defs::*;
#(
    parameter int Depth = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [EntryWidth-1:0]     wr_data,
    input  logic                      rd_req,
    output logic [EntryWidth-1:0]     rd_data,
    output logic                      rd_valid,
    output logic [$clog2(Depth):0]    level,
    output logic                      wr_drop
);

    localparam int PtrW = $clog2(Depth);
    localparam int LvlW = PtrW + 1;

    logic [EntryWidth-1:0] mem_q [Depth];
    logic [EntryWidth-1:0] mem_d [Depth];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q,  level_d;
    logic                  full_s, empty_s, push_s, pop_s;

    // Push/pop qualification; a full FIFO still accepts a write when a pop frees the slot.
    always_comb begin
        full_s  = (level_q == LvlW'(Depth));
        empty_s = (level_q == LvlW'(0));
        pop_s   = rd_req & ~empty_s;
        push_s  = wr_en & (~full_s | pop_s);
        wr_drop = wr_en & full_s & ~pop_s;
    end

    // Next pointers, level and storage; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers; clearing them is what discards the contents on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are only meaningful behind valid pointers, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Show-ahead outputs driven from registered state.
    always_comb begin
        rd_data  = mem_q[rd_ptr_q];
        rd_valid = ~empty_s;
        level    = level_q;
    end

endmodule

// File: rtl/receive_controller.sv
// Receive controller: handshakes bytes from the UART Receiver into a receive
// FIFO and exposes them to the host with status and an interrupt.
// Ports:
//   OverSamplingClock, Reset           - clock, asynchronous active-low reset
//   RxData, RxError, RxInterrupt       - byte, error code and byte-ready from Receiver
//   RxAcknowledge                      - handshake back to the Receiver
//   ReadRequest, ReadData, ReadError   - host pop strobe and show-ahead head entry
//   ReadValid, Level                   - FIFO non-empty and occupancy
//   OverrunFlag, ErrorCount            - sticky drop flag, saturating error counter
//   StatusClear                        - clears OverrunFlag and ErrorCount
//   HostIrq                            - ReadValid OR OverrunFlag
module receive_controller
    import uart_defs::*;
#(
    parameter int FifoDepth       = 4,
    parameter int ErrorCountWidth = 8
) (
    input  logic                          OverSamplingClock,
    input  logic                          Reset,
    input  logic [DataWidth-1:0]          RxData,
    input  logic [ErrorWidth-1:0]         RxError,
    input  logic                          RxInterrupt,
    output logic                          RxAcknowledge,
    input  logic                          ReadRequest,
    output logic [DataWidth-1:0]          ReadData,
    output logic [ErrorWidth-1:0]         ReadError,
    output logic                          ReadValid,
    output logic [$clog2(FifoDepth):0]    Level,
    output logic                          OverrunFlag,
    output logic [ErrorCountWidth-1:0]    ErrorCount,
    input  logic                          StatusClear,
    output logic                          HostIrq
);

    rx_state_e                   state_q, state_d;
    logic                        ack_q, ack_d;
    logic                        overrun_q, overrun_d;
    logic [ErrorCountWidth-1:0]  err_cnt_q, err_cnt_d;
    logic                        wr_en_s, wr_drop_s;
    logic [EntryWidth-1:0]       head_s;

    receive_fifo #(.Depth(FifoDepth)) u_fifo (
        .clk      (OverSamplingClock),
        .rst_n    (Reset),
        .wr_en    (wr_en_s),
        .wr_data  (pack_entry(RxError, RxData)),
        .rd_req   (ReadRequest),
        .rd_data  (head_s),
        .rd_valid (ReadValid),
        .level    (Level),
        .wr_drop  (wr_drop_s)
    );

    // Handshake FSM: one FIFO write per RxInterrupt high period, taken in Capture.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        wr_en_s = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (RxInterrupt) begin
                    state_d = RX_CAPTURE;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_CAPTURE: begin
                wr_en_s = 1'b1;
                ack_d   = 1'b1;
                state_d = RX_ACKNOWLEDGE;
            end
            RX_ACKNOWLEDGE: begin
                if (!RxInterrupt) begin
                    ack_d   = 1'b0;
                    state_d = RX_IDLE;
                end else begin
                    ack_d   = 1'b1;
                    state_d = RX_ACKNOWLEDGE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = RX_IDLE;
            end
        endcase
    end

    // Status: StatusClear dominates a same-cycle overrun or error increment.
    always_comb begin
        overrun_d = overrun_q;
        err_cnt_d = err_cnt_q;
        if (StatusClear) begin
            overrun_d = 1'b0;
            err_cnt_d = '0;
        end else begin
            overrun_d = overrun_q | wr_drop_s;
            // Counted on capture even if the byte is then dropped; saturates at all-ones.
            if (wr_en_s && (RxError != ErrorWidth'(0)) &&
                (err_cnt_q != {ErrorCountWidth{1'b1}})) begin
                err_cnt_d = err_cnt_q + ErrorCountWidth'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end
    end

    // Controller state, handshake and status registers.
    always_ff @(posedge OverSamplingClock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= RX_IDLE;
            ack_q     <= 1'b0;
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Output mapping; HostIrq is combinational from registered flags.
    always_comb begin
        RxAcknowledge = ack_q;
        ReadData      = head_s[DataWidth-1:0];
        ReadError     = head_s[EntryWidth-1:DataWidth];
        OverrunFlag   = overrun_q;
        ErrorCount    = err_cnt_q;
        HostIrq       = ReadValid | overrun_q;
    end

endmodule

// File: tb/tb_receive_controller.sv
// Self-checking bench for receive_controller: directed scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_receive_controller;

    localparam int Depth  = 4;
    localparam int CntW   = 8;
    localparam int LvlW   = $clog2(Depth) + 1;
    localparam int CntMax = (1 << CntW) - 1;

    logic            clk = 1'b0;
    logic            Reset;
    logic [7:0]      RxData;
    logic [2:0]      RxError;
    logic            RxInterrupt;
    logic            RxAcknowledge;
    logic            ReadRequest;
    logic [7:0]      ReadData;
    logic [2:0]      ReadError;
    logic            ReadValid;
    logic [LvlW-1:0] Level;
    logic            OverrunFlag;
    logic [CntW-1:0] ErrorCount;
    logic            StatusClear;
    logic            HostIrq;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: byte queue, sticky flag, counter, handshake progress.
    logic [10:0] m_q[$];
    bit          m_ovr;
    int          m_cnt;
    bit          m_ack;
    bit          m_cap_pend;

    receive_controller #(.FifoDepth(Depth), .ErrorCountWidth(CntW)) dut (
        .OverSamplingClock (clk),
        .Reset             (Reset),
        .RxData            (RxData),
        .RxError           (RxError),
        .RxInterrupt       (RxInterrupt),
        .RxAcknowledge     (RxAcknowledge),
        .ReadRequest       (ReadRequest),
        .ReadData          (ReadData),
        .ReadError         (ReadError),
        .ReadValid         (ReadValid),
        .Level             (Level),
        .OverrunFlag       (OverrunFlag),
        .ErrorCount        (ErrorCount),
        .StatusClear       (StatusClear),
        .HostIrq           (HostIrq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovr      = 1'b0;
        m_cnt      = 0;
        m_ack      = 1'b0;
        m_cap_pend = 1'b0;
    endtask

    task automatic check_outputs();
        check("ack",    32'(RxAcknowledge), 32'(m_ack));
        check("level",  32'(Level),         32'(m_q.size()));
        check("valid",  32'(ReadValid),     32'(m_q.size() != 0));
        check("ovr",    32'(OverrunFlag),   32'(m_ovr));
        check("errcnt", 32'(ErrorCount),    32'(m_cnt));
        check("irq",    32'(HostIrq),       32'((m_q.size() != 0) || m_ovr));
        if (m_q.size() != 0) begin
            check("rdata", 32'(ReadData),  32'(m_q[0][7:0]));
            check("rerr",  32'(ReadError), 32'(m_q[0][10:8]));
        end
    endtask

    // One clock: apply inputs, advance the model by the rules, then compare.
    task automatic step(input bit rx_int, input logic [7:0] d, input logic [2:0] e,
                        input bit rd, input bit clr);
        bit pop, cap;
        RxInterrupt = rx_int;
        RxData      = d;
        RxError     = e;
        ReadRequest = rd;
        StatusClear = clr;
        pop = rd && (m_q.size() != 0);
        cap = m_cap_pend;
        if (m_cap_pend) begin
            m_cap_pend = 1'b0;
            m_ack      = 1'b1;
        end else if (m_ack) begin
            if (!rx_int) m_ack = 1'b0;
        end else if (rx_int) begin
            m_cap_pend = 1'b1;
        end
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            if (m_q.size() < Depth) m_q.push_back({e, d});
            else m_ovr = 1'b1;
            if (e != 3'd0 && m_cnt < CntMax) m_cnt++;
        end
        if (clr) begin
            m_ovr = 1'b0;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [2:0] e,
                             input int hi, input int lo, input int rd_at);
        for (int i = 0; i < hi + lo; i++) begin
            step(i < hi, d, e, i == rd_at, 1'b0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < Depth + 2; i++) begin
            step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        Reset       = 1'b0;
        RxData      = 8'h00;
        RxError     = 3'd0;
        RxInterrupt = 1'b0;
        ReadRequest = 1'b0;
        StatusClear = 1'b0;
        model_reset();
        #2;
        check_outputs();
        @(posedge clk);
        #2;
        Reset = 1'b1;

        // Single byte 0xAA, interrupt held 5 cycles.
        send_byte(8'hAA, 3'd0, 5, 2, -1);
        check("s37_data", 32'(ReadData), 32'h0000_00AA);
        check("s37_level", 32'(Level), 32'd1);
        drain();

        // Five bytes with no reads: fifth is dropped.
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 3'd0, 2, 1, -1);
        check("s38_level", 32'(Level), 32'd4);
        check("s38_ovr", 32'(OverrunFlag), 32'd1);
        check("s38_irq", 32'(HostIrq), 32'd1);
        drain();
        check("s38_empty", 32'(ReadValid), 32'd0);

        // Full FIFO, capture coincides with a pop.
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        for (int b = 0; b < 4; b++) send_byte(8'(8'h10 + b), 3'd1, 2, 1, -1);
        send_byte(8'h55, 3'd0, 3, 1, 1);
        check("s39_ovr", 32'(OverrunFlag), 32'd0);
        check("s39_level", 32'(Level), 32'd4);
        drain();

        // 300 error bytes, popping each, counter saturates.
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        for (int b = 0; b < 300; b++) send_byte(8'(b), 3'b010, 2, 1, 2);
        check("s40_sat", 32'(ErrorCount), 32'd255);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        check("s40_clr", 32'(ErrorCount), 32'd0);

        // Pops while empty are ignored.
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        send_byte(8'hC3, 3'd4, 2, 1, -1);
        drain();

        // Random traffic.
        for (int b = 0; b < 200; b++) begin
            logic [7:0] d;
            logic [2:0] e;
            int hi, lo;
            d  = 8'($urandom);
            e  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
            hi = $urandom_range(1, 5);
            lo = $urandom_range(1, 3);
            for (int i = 0; i < hi + lo; i++) begin
                step(i < hi, d, e, $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
            end
        end
        drain();

        // Reset in the middle of Acknowledge with two bytes stored.
        send_byte(8'h66, 3'd0, 2, 1, -1);
        step(1'b1, 8'h77, 3'd0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 3'd0, 1'b0, 1'b0);
        check("s41_pre_ack", 32'(RxAcknowledge), 32'd1);
        check("s41_pre_lvl", 32'(Level), 32'd2);
        #1;
        Reset = 1'b0;
        #1;
        check("s41_ack", 32'(RxAcknowledge), 32'd0);
        check("s41_level", 32'(Level), 32'd0);
        check("s41_valid", 32'(ReadValid), 32'd0);
        check("s41_irq", 32'(HostIrq), 32'd0);
        model_reset();
        #1;
        Reset = 1'b1;
        // Interrupt still high after reset: a fresh byte.
        step(1'b1, 8'h3C, 3'd0, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 3'd0, 1'b0, 1'b0);
        step(1'b0, 8'h3C, 3'd0, 1'b0, 1'b0);
        check("s34_data", 32'(ReadData), 32'h0000_003C);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/receive_controller.md
RECEIVE_CONTROLLER -- requirements
Module: receive_controller

Interface
REQ-001 SHALL have parameter FifoDepth, default 4, meaning receive FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter ErrorCountWidth, default 8, meaning error counter width.
REQ-003 SHALL have port OverSamplingClock  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RxData  input  8  byte from the Receiver DataOut.
REQ-006 SHALL have port RxError  input  3  error code from the Receiver ErrorOut; zero means no error.
REQ-007 SHALL have port RxInterrupt  input  1  byte-ready from the Receiver HostInterrupt.
REQ-008 SHALL have port RxAcknowledge  output  1  drives the Receiver HostAcknowledge.
REQ-009 SHALL have port ReadRequest  input  1  host pop strobe.
REQ-010 SHALL have port ReadData  output  8  FIFO head byte (show-ahead).
REQ-011 SHALL have port ReadError  output  3  error code stored with the head byte.
REQ-012 SHALL have port ReadValid  output  1  FIFO non-empty.
REQ-013 SHALL have port Level  output  log2(FifoDepth)+1  FIFO occupancy.
REQ-014 SHALL have port OverrunFlag  output  1  sticky; a byte was dropped.
REQ-015 SHALL have port ErrorCount  output  ErrorCountWidth  count of bytes with nonzero RxError.
REQ-016 SHALL have port StatusClear  input  1  clears OverrunFlag and ErrorCount.
REQ-017 SHALL have port HostIrq  output  1  ReadValid OR OverrunFlag, combinational.

Function
REQ-018 SHALL implement FSM states Idle, Capture, Acknowledge.
REQ-019 In Idle, RxInterrupt sampled high SHALL move the FSM to Capture on that edge.
REQ-020 In Capture, on the next edge the FSM SHALL latch {RxError, RxData}, attempt one FIFO write, set RxAcknowledge high, and enter Acknowledge.
REQ-021 In Acknowledge, RxAcknowledge SHALL stay high until RxInterrupt is sampled low; on that edge RxAcknowledge SHALL go low and the FSM SHALL return to Idle.
REQ-022 Exactly one FIFO write SHALL occur per RxInterrupt high period, regardless of its duration.
REQ-023 The write SHALL be accepted when Level < FifoDepth, or when Level == FifoDepth and a pop occurs in the same cycle. In the latter case Level is unchanged.
REQ-024 A write refused because the FIFO is full SHALL discard the byte and set OverrunFlag on the same edge.
REQ-025 A pop SHALL occur when ReadRequest and ReadValid are both high: the read pointer advances and Level decrements on that edge.
REQ-026 ReadRequest while empty SHALL be ignored, with no pointer or Level change.
REQ-027 A simultaneous write and pop SHALL leave Level unchanged.
REQ-028 Pointers SHALL wrap modulo FifoDepth.
REQ-029 ReadData and ReadError SHALL reflect the head entry combinationally and are don't-care when ReadValid is low.
REQ-030 ErrorCount SHALL increment on every Capture with nonzero RxError, including discarded bytes, and SHALL saturate at all-ones.
REQ-031 StatusClear SHALL clear OverrunFlag and ErrorCount on the edge. It SHALL win over a same-cycle set or increment. FIFO contents SHALL be unaffected.

Reset
REQ-032 Reset low SHALL immediately force: FSM to Idle, RxAcknowledge 0, pointers 0, Level 0, ReadValid 0, OverrunFlag 0, ErrorCount 0, HostIrq 0.
REQ-033 Reset asserted mid-Acknowledge SHALL drop RxAcknowledge at once and discard FIFO contents.
REQ-034 After Reset rises, if RxInterrupt is still high, it SHALL be treated as a new byte.

Structure
REQ-035 A shared package uart_defs SHALL hold DataWidth=8, ErrorWidth=3, and the FSM state encodings, shared with the Receiver.
REQ-036 The FIFO SHALL be one sub-module, receive_fifo, holding storage, pointers, Level and the full/empty logic. The FSM, status and counters SHALL reside in receive_controller.

Verification
REQ-037 Scenario: RxData=0xAA, RxError=0, RxInterrupt high for 5 cycles. Required: RxAcknowledge rises 2 edges after RxInterrupt and falls 1 edge after it drops; ReadValid=1; ReadData=0xAA; Level=1.
REQ-038 Scenario: 5 bytes 0x01..0x05 with no reads, FifoDepth=4. Required: Level=4, OverrunFlag=1, HostIrq=1; popping returns 0x01..0x04 in order; Level reaches 0 and ReadValid=0.
REQ-039 Scenario: FIFO full; capture 0x55 in the same cycle ReadRequest=1. Required: no overrun, Level stays 4, head advances, 0x55 is read last.
REQ-040 Scenario: 300 bytes with RxError=3'b010, popping each. Required: ErrorCount=255 (saturated); each ReadError=3'b010; then StatusClear gives ErrorCount=0.
REQ-041 Scenario: Reset low while RxAcknowledge=1 and Level=2. Required: RxAcknowledge=0, Level=0, ReadValid=0 immediately, without waiting for a clock edge.
REQ-042 Scenario: ReadRequest held high while empty for 10 cycles. Required: Level stays 0; next captured byte reads correctly.
